// File: rtl/plantard_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : plantard_pkg
//  Description : Shared widths, iteration count, legality limits and FSM
//                state encoding for the Plantard operand pre-computation.
//  Revision    : 1.0  initial release
// ============================================================================
package plantard_pkg;

    localparam int W            = 64;
    localparam int NEWTON_ITERS = 5;

    localparam logic [7:0] K1_MIN = 8'd1;
    localparam logic [7:0] M_MIN  = 8'd1;
    localparam logic [8:0] KM_MAX = 9'd31;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_NEWT_A = 3'd2,
        S_NEWT_B = 3'd3,
        S_FINAL  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mul_lo64.sv
`default_nettype none
// ============================================================================
//  Module      : mul_lo64
//  Description : Registered W x W -> W low-half multiplier assembled from
//                16x16 partial products; terms landing at or above bit W
//                are never formed.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_lo64
    import plantard_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_p
);

    localparam int c_LIMBS = W / 16;

    logic [31:0]  w_pp;
    logic [W-1:0] w_sum;

    always_comb begin
        w_pp  = '0;
        w_sum = '0;
        for (int i = 0; i < c_LIMBS; i++) begin
            for (int j = 0; j < c_LIMBS - i; j++) begin
                w_pp  = {16'd0, i_a[16*i +: 16]} * {16'd0, i_b[16*j +: 16]};
                w_sum = w_sum + (W'(w_pp) << (16 * (i + j)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_p <= '0;
        end else begin
            o_p <= w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/plantard_precomp.sv
`default_nettype none
// ============================================================================
//  Module      : plantard_precomp
//  Description : Derives q = 2^m*(2^k1-1)+1, q^-1 mod 2^W (Newton) and
//                b' = b*q^-1 mod 2^W on one shared registered multiplier.
//  Revision    : 1.0  initial release
// ============================================================================
module plantard_precomp
    import plantard_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  b_in,
    input  logic [7:0]   k1,
    input  logic [7:0]   m,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] q,
    output logic [W-1:0] q_inv,
    output logic [W-1:0] b_pre,
    output logic [7:0]   k1_o,
    output logic [7:0]   m_o
);

    localparam logic [2:0]   c_LAST_ITER = 3'(NEWTON_ITERS - 1);
    localparam logic [W-1:0] c_ONE       = W'(1);
    localparam logic [W-1:0] c_TWO       = W'(2);

    state_t       r_state;
    logic [2:0]   r_cnt;
    logic [31:0]  r_b;
    logic [7:0]   r_k1;
    logic [7:0]   r_m;
    logic [W-1:0] r_q;
    logic [W-1:0] r_x;

    logic [W-1:0] w_q;
    logic         w_legal;
    logic [W-1:0] w_mul_a;
    logic [W-1:0] w_mul_b;
    logic [W-1:0] w_prod;

    assign w_q     = (((c_ONE << r_k1) - c_ONE) << r_m) + c_ONE;
    assign w_legal = (r_k1 >= K1_MIN) && (r_m >= M_MIN) &&
                     (({1'b0, r_k1} + {1'b0, r_m}) <= KM_MAX);

    // The multiply schedule runs one slot ahead of the state names: INIT
    // forms t0 = q*q, NEWT_A forms x = x*(2-t), NEWT_B forms the next t, and
    // the last NEWT_B forms b*x so FINAL can register every result at once.
    always_comb begin
        w_mul_a = r_x;
        w_mul_b = c_TWO - w_prod;
        case (r_state)
            S_INIT: begin
                w_mul_a = w_q;
                w_mul_b = w_q;
            end
            S_NEWT_B: begin
                w_mul_a = (r_cnt == c_LAST_ITER) ? W'(r_b) : r_q;
                w_mul_b = w_prod;
            end
            default: ;
        endcase
    end

    mul_lo64 u_mul (
        .clk (clk),
        .rst (rst),
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_b     <= '0;
            r_k1    <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_x     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            q       <= '0;
            q_inv   <= '0;
            b_pre   <= '0;
            k1_o    <= '0;
            m_o     <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_b     <= b_in;
                        r_k1    <= k1;
                        r_m     <= m;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_INIT;
                    end
                end
                S_INIT: begin
                    if (w_legal) begin
                        r_q     <= w_q;
                        r_x     <= w_q;
                        r_state <= S_NEWT_A;
                    end else begin
                        q       <= '0;
                        q_inv   <= '0;
                        b_pre   <= '0;
                        err     <= 1'b1;
                        k1_o    <= r_k1;
                        m_o     <= r_m;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_NEWT_A: begin
                    r_state <= S_NEWT_B;
                end
                S_NEWT_B: begin
                    r_x   <= w_prod;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == c_LAST_ITER) begin
                        r_state <= S_FINAL;
                    end else begin
                        r_state <= S_NEWT_A;
                    end
                end
                S_FINAL: begin
                    q       <= r_q;
                    q_inv   <= r_x;
                    b_pre   <= w_prod;
                    err     <= 1'b0;
                    k1_o    <= r_k1;
                    m_o     <= r_m;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
